// File: rtl/addsub_pkg.sv
// Shared operation encoding and carry-in helpers for the pipelined adder/subtractor.
// The per-stage payload struct depends on WIDTH/TAG_W and is therefore declared in the top.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_t;

    // Subtracting modes feed the one's complement of B into the chain
    function automatic logic op_inverts_b(input op_t op);
        return op[0];
    endfunction

    function automatic logic op_carry_in(input op_t op, input logic cin);
        logic c0;
        case (op)
            OP_ADD:  c0 = 1'b0;
            OP_SUB:  c0 = 1'b1;
            OP_ADC:  c0 = cin;
            OP_SBC:  c0 = cin;
            default: c0 = 1'b0;
        endcase
        return c0;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple adder; the carry into the MSB is exposed so the
// final stage can derive signed overflow.
module addsub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [CHUNK:0] carry_s;

    // Bit-serial ripple through the chunk
    always_comb begin
        carry_s    = {(CHUNK + 1){1'b0}};
        sum        = {CHUNK{1'b0}};
        carry_s[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
        cout    = carry_s[CHUNK];
        msb_cin = carry_s[CHUNK-1];
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ADD/SUB/ADC/SBC: one CHUNK of the carry chain per stage, carry registered
// between stages, valid/ready flow control with per-stage stall and flush.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CHUNK = WIDTH / STAGES;

    // a_rem/b_rem are shifted down each stage so the next chunk always sits at bit 0
    typedef struct packed {
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic [WIDTH-1:0] sum_acc;
        logic             carry;
        logic             ovf;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t            stage_r [STAGES];
    stage_t            next_s  [STAGES];
    stage_t            entry_s;
    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] adv_s;
    logic [STAGES-1:0] load_s;
    logic              ready_s;
    logic              zero_r;

    // Condition operands for stage 0: conditional B inversion and initial carry
    always_comb begin
        entry_s       = {$bits(stage_t){1'b0}};
        entry_s.a_rem = in_a;
        entry_s.b_rem = in_b ^ {WIDTH{op_inverts_b(op_t'(in_op))}};
        entry_s.carry = op_carry_in(op_t'(in_op), in_cin);
        entry_s.tag   = in_tag;
    end

    // Backward ready chain and per-stage load enables
    always_comb begin
        adv_s           = {STAGES{1'b0}};
        load_s          = {STAGES{1'b0}};
        adv_s[STAGES-1] = valid_r[STAGES-1] & out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv_s[k] = valid_r[k] & (~valid_r[k+1] | adv_s[k+1]);
        end
        ready_s   = (~valid_r[0] | adv_s[0]) & ~flush;
        load_s[0] = in_valid & ready_s;
        for (int k = 1; k < STAGES; k++) begin
            load_s[k] = adv_s[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           src_s;
        stage_t           nxt_loc_s;
        logic [CHUNK-1:0] sum_s;
        logic             cout_s;
        logic             msb_cin_s;

        if (k == 0) begin : g_head
            assign src_s = entry_s;
        end else begin : g_body
            assign src_s = stage_r[k-1];
        end

        addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a       (src_s.a_rem[CHUNK-1:0]),
            .b       (src_s.b_rem[CHUNK-1:0]),
            .cin     (src_s.carry),
            .sum     (sum_s),
            .cout    (cout_s),
            .msb_cin (msb_cin_s)
        );

        // Retire chunk k into the accumulated sum and expose its carry/overflow
        always_comb begin
            nxt_loc_s                            = src_s;
            nxt_loc_s.a_rem                      = src_s.a_rem >> CHUNK;
            nxt_loc_s.b_rem                      = src_s.b_rem >> CHUNK;
            nxt_loc_s.sum_acc[k*CHUNK +: CHUNK]  = sum_s;
            nxt_loc_s.carry                      = cout_s;
            nxt_loc_s.ovf                        = cout_s ^ msb_cin_s;
        end

        assign next_s[k] = nxt_loc_s;
    end

    // Pipeline registers: a stage captures only when loaded, otherwise it holds
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {STAGES{1'b0}};
            zero_r  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                stage_r[k] <= {$bits(stage_t){1'b0}};
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load_s[k]) begin
                    stage_r[k] <= next_s[k];
                end
                valid_r[k] <= ~flush & (load_s[k] | (valid_r[k] & ~adv_s[k]));
            end
            if (load_s[STAGES-1]) begin
                zero_r <= (next_s[STAGES-1].sum_acc == {WIDTH{1'b0}});
            end
        end
    end

    assign in_ready  = ready_s;
    assign out_valid = valid_r[STAGES-1];
    assign out_sum   = stage_r[STAGES-1].sum_acc;
    assign out_cout  = stage_r[STAGES-1].carry;
    assign out_ovf   = stage_r[STAGES-1].ovf;
    assign out_zero  = zero_r;
    assign out_tag   = stage_r[STAGES-1].tag;

endmodule
